// File: rtl/z_buffer_mem_responder_if.sv
// Request/response bus between the rasteriser's z-test unit (master) and the
// on-chip depth memory responder (slave).
interface z_buffer_mem_responder_if #(
  parameter int Z_SIZE    = 8,
  parameter int ADDR_SIZE = 32
);
  logic                 buf_r_w;
  logic [ADDR_SIZE-1:0] buf_addr;
  logic [Z_SIZE-1:0]    buf_data_w;
  logic [Z_SIZE-1:0]    buf_data_r;
  logic                 data_r_ready;
  logic                 data_r_valid;
  logic                 data_w_valid;
  logic                 data_w_ready;

  modport master (
    output buf_r_w, buf_addr, buf_data_w, data_r_ready, data_w_valid,
    input  buf_data_r, data_r_valid, data_w_ready
  );

  modport slave (
    input  buf_r_w, buf_addr, buf_data_w, data_r_ready, data_w_valid,
    output buf_data_r, data_r_valid, data_w_ready
  );
endinterface

// File: rtl/z_buffer_mem_responder.sv
// On-chip depth buffer serving z-test reads/writes with programmable latency,
// plus a word-per-cycle hardware clear and sticky out-of-range error flag.
module z_buffer_mem_responder #(
  parameter int Z_SIZE     = 8,
  parameter int X_RES      = 4,
  parameter int Y_RES      = 4,
  parameter int DEPTH      = X_RES * Y_RES,
  parameter int ADDR_SIZE  = 32,
  parameter int RD_LATENCY = 2,
  parameter int WR_LATENCY = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [ADDR_SIZE-1:0]   base_address_i,
  z_buffer_mem_responder_if.slave bus,
  input  logic                   clear_i,
  output logic                   busy_o,
  output logic                   addr_err_o,
  input  logic                   err_clr_i
);

  localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  localparam int MAX_CNT = (MAX_LAT > DEPTH) ? MAX_LAT : DEPTH;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(RD_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_LAST  = CNT_W'(WR_LATENCY - 1);
  localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_RESP,
    WR_WAIT,
    WR_ACK,
    CLEAR
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_next;

  logic [Z_SIZE-1:0]    mem [DEPTH];
  logic [ADDR_SIZE-1:0] req_offset;
  logic                 req_in_range;

  logic [IDX_W-1:0]     idx_q;
  logic                 in_range_q;
  logic [Z_SIZE-1:0]    wdata_q;
  logic [Z_SIZE-1:0]    rdata_q;

  logic                 accept_rd;
  logic                 accept_wr;
  logic                 load_rd;
  logic                 commit_wr;
  logic                 clear_we;

  // Unsigned wrap makes addresses below the base land far out of range.
  assign req_offset   = bus.buf_addr - base_address_i;
  assign req_in_range = (bus.buf_addr >= base_address_i) &&
                        (req_offset < ADDR_SIZE'(DEPTH));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept_rd  = 1'b0;
    accept_wr  = 1'b0;
    load_rd    = 1'b0;
    commit_wr  = 1'b0;
    clear_we   = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_next = '0;
        if (clear_i) begin
          state_next = CLEAR;
        end else if (bus.data_w_valid && !bus.buf_r_w) begin
          accept_wr  = 1'b1;
          state_next = WR_WAIT;
        end else if (bus.data_r_ready && bus.buf_r_w) begin
          accept_rd  = 1'b1;
          state_next = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (cnt == RD_LAST) begin
          load_rd    = 1'b1;
          cnt_next   = '0;
          state_next = RD_RESP;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      RD_RESP: begin
        if (bus.data_r_ready) begin
          state_next = IDLE;
        end
      end
      WR_WAIT: begin
        if (cnt == WR_LAST) begin
          cnt_next   = '0;
          state_next = WR_ACK;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      WR_ACK: begin
        commit_wr  = 1'b1;
        state_next = IDLE;
      end
      CLEAR: begin
        clear_we = 1'b1;
        if (cnt == CLR_LAST) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Request capture, read data register and sticky error; memory is not reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q      <= '0;
      in_range_q <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      addr_err_o <= 1'b0;
    end else begin
      if (accept_rd || accept_wr) begin
        idx_q      <= req_offset[IDX_W-1:0];
        in_range_q <= req_in_range;
      end
      if (accept_wr) begin
        wdata_q <= bus.buf_data_w;
      end
      if (load_rd) begin
        rdata_q <= in_range_q ? mem[idx_q] : '1;
      end
      if ((accept_rd || accept_wr) && !req_in_range) begin
        addr_err_o <= 1'b1;
      end else if (err_clr_i) begin
        addr_err_o <= 1'b0;
      end
    end
  end

  // A reset on the same edge suppresses any pending write or clear step.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (clear_we) begin
        mem[cnt[IDX_W-1:0]] <= '1;
      end else if (commit_wr && in_range_q) begin
        mem[idx_q] <= wdata_q;
      end
    end
  end

  assign bus.buf_data_r   = rdata_q;
  assign bus.data_r_valid = (state == RD_RESP);
  assign bus.data_w_ready = (state == WR_ACK);
  assign busy_o           = (state != IDLE);

endmodule
